// File: rtl/ex_stage_if.sv
// ID/EX to EX/MEM bundle for the execute stage.
// master drives the ID/EX side, slave is the execute stage.
interface ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6
);
    logic              stall;
    logic              validIn;
    logic              RegWrtIn;
    logic              memToRegIn;
    logic              PCtoRegIn;
    logic              BranchNIn;
    logic              BranchZIn;
    logic              JumpIn;
    logic              JumpMemIn;
    logic              memReadIn;
    logic              memWriteIn;
    logic              immeIn;
    logic [1:0]        ALUopIn;
    logic [DATA_W-1:0] XrsIn;
    logic [DATA_W-1:0] XrtIn;
    logic [DATA_W-1:0] Yin;
    logic [DATA_W-1:0] PC_YIn;
    logic [RD_W-1:0]   rdIn;

    logic              validOut;
    logic              RegWrtOut;
    logic              memToRegOut;
    logic              memReadOut;
    logic              memWriteOut;
    logic              JumpMemOut;
    logic [DATA_W-1:0] resultOut;
    logic [DATA_W-1:0] addrOut;
    logic [DATA_W-1:0] storeOut;
    logic [RD_W-1:0]   rdOut;
    logic              redirect;
    logic [DATA_W-1:0] redirectPC;
    logic              flagN;
    logic              flagZ;

    modport master (
        output stall, validIn, RegWrtIn, memToRegIn, PCtoRegIn,
        output BranchNIn, BranchZIn, JumpIn, JumpMemIn,
        output memReadIn, memWriteIn, immeIn, ALUopIn,
        output XrsIn, XrtIn, Yin, PC_YIn, rdIn,
        input  validOut, RegWrtOut, memToRegOut, memReadOut,
        input  memWriteOut, JumpMemOut, resultOut, addrOut,
        input  storeOut, rdOut, redirect, redirectPC, flagN, flagZ
    );

    modport slave (
        input  stall, validIn, RegWrtIn, memToRegIn, PCtoRegIn,
        input  BranchNIn, BranchZIn, JumpIn, JumpMemIn,
        input  memReadIn, memWriteIn, immeIn, ALUopIn,
        input  XrsIn, XrtIn, Yin, PC_YIn, rdIn,
        output validOut, RegWrtOut, memToRegOut, memReadOut,
        output memWriteOut, JumpMemOut, resultOut, addrOut,
        output storeOut, rdOut, redirect, redirectPC, flagN, flagZ
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, N/Z flags, branch resolve and post-redirect squash.
// All state advances on the falling clock edge.
module ex_stage #(
    parameter int DATA_W       = 32,
    parameter int RD_W         = 6,
    parameter int SQUASH_DEPTH = 2
) (
    input logic      clk,
    input logic      rst_n,
    ex_stage_if.slave ex
);
    localparam int CW = $clog2(SQUASH_DEPTH + 1);

    logic [CW-1:0]     sq_cnt;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] res;
    logic              go;
    logic              eff;
    logic              sqsh;
    logic              taken;
    logic              fupd;

    always_comb begin
        opb = ex.immeIn ? ex.Yin : ex.XrtIn;
        alu = '0;
        unique case (ex.ALUopIn)
            2'b00: alu = ex.XrsIn + opb;
            2'b01: alu = ex.XrsIn + ex.Yin;
            2'b10: alu = '0 - ex.XrsIn;
            2'b11: alu = ex.XrsIn - opb;
        endcase
        res = ex.PCtoRegIn ? ex.PC_YIn : alu;
    end

    assign go    = ex.validIn & ~ex.stall;
    assign eff   = go & (sq_cnt == '0);
    assign sqsh  = go & (sq_cnt != '0);
    // Flags used here are the ones registered before this edge
    assign taken = eff & (ex.JumpIn
                        | (ex.BranchZIn & ex.flagZ)
                        | (ex.BranchNIn & ex.flagN));
    assign fupd  = eff & ex.RegWrtIn & ~ex.memToRegIn & ~ex.PCtoRegIn;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex.validOut    <= 1'b0;
            ex.RegWrtOut   <= 1'b0;
            ex.memToRegOut <= 1'b0;
            ex.memReadOut  <= 1'b0;
            ex.memWriteOut <= 1'b0;
            ex.JumpMemOut  <= 1'b0;
            ex.resultOut   <= '0;
            ex.addrOut     <= '0;
            ex.storeOut    <= '0;
            ex.rdOut       <= '0;
            ex.redirect    <= 1'b0;
            ex.redirectPC  <= '0;
            ex.flagN       <= 1'b0;
            ex.flagZ       <= 1'b0;
            sq_cnt         <= '0;
        end else if (ex.stall) begin
            ex.redirect <= 1'b0;
        end else begin
            ex.validOut    <= eff;
            ex.RegWrtOut   <= eff & ex.RegWrtIn;
            ex.memToRegOut <= eff & ex.memToRegIn;
            ex.memReadOut  <= eff & ex.memReadIn;
            ex.memWriteOut <= eff & ex.memWriteIn;
            ex.JumpMemOut  <= eff & ex.JumpMemIn;
            ex.resultOut   <= eff ? res : '0;
            ex.addrOut     <= eff ? ex.XrsIn : '0;
            ex.storeOut    <= eff ? ex.XrtIn : '0;
            ex.rdOut       <= eff ? ex.rdIn : '0;
            ex.redirect    <= taken;
            ex.redirectPC  <= taken ? ex.XrsIn : '0;
            if (fupd) begin
                ex.flagN <= res[DATA_W-1];
                ex.flagZ <= (res == '0);
            end
            if (taken)
                sq_cnt <= CW'(SQUASH_DEPTH);
            else if (sqsh)
                sq_cnt <= sq_cnt - CW'(1);
        end
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; consumes the ID/EX register bundle and produces the EX/MEM bundle.
- Performs ALU ops and holds the N/Z condition flags.
- Resolves BRN/BRZ/J and issues a one-cycle PC redirect.
- After a taken redirect, squashes the next SQUASH_DEPTH younger instructions already in flight.

Parameters:
DATA_W, 32, datapath width
RD_W, 6, destination register index width
SQUASH_DEPTH, 2, younger instructions squashed after a taken redirect (1..3)

Ports:
clk  in  1  pipeline clock; all state updates on negedge clk
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all state and outputs this cycle
validIn  in  1  ID/EX slot holds a real instruction
RegWrtIn, memToRegIn, PCtoRegIn, BranchNIn, BranchZIn, JumpIn, JumpMemIn, memReadIn, memWriteIn, immeIn  in  1 each  ID/EX control bits
ALUopIn  in  2  00 ADD, 01 INC, 10 NEG, 11 SUB
XrsIn, XrtIn, Yin, PC_YIn  in  DATA_W each  operands, immediate, PC+Y
rdIn  in  RD_W  destination register
validOut  out  1  EX/MEM slot valid
RegWrtOut, memToRegOut, memReadOut, memWriteOut, JumpMemOut  out  1 each  forwarded control bits
resultOut  out  DATA_W  ALU result or PC+Y
addrOut  out  DATA_W  memory address (= Xrs)
storeOut  out  DATA_W  store data (= Xrt)
rdOut  out  RD_W  destination register
redirect  out  1  one-cycle taken-branch/jump pulse
redirectPC  out  DATA_W  target (= Xrs), valid while redirect=1
flagN, flagZ  out  1 each  architectural condition flags

Behaviour:
- Reset (async, rst_n=0):
  - All outputs cleared to 0.
  - Squash counter = 0.
  - flagN = flagZ = 0.
  - Release takes effect at the next negedge.
- Operand B: Yin if immeIn=1, else XrtIn.
- ALU operations (modulo 2^DATA_W, no overflow flag):
  - ADD: Xrs+B.
  - INC: Xrs+Yin.
  - NEG: 0-Xrs.
  - SUB: Xrs-B.
- resultOut = PC_YIn if PCtoRegIn=1, else the ALU result.
- Latency: one negedge, ID/EX to EX/MEM.
- Effective instruction: validIn=1, stall=0, squash counter = 0.
- Squashed instruction: validIn=1, stall=0, counter > 0.
  - Counter decrements by 1.
  - validOut=0; all control outs 0; no flag update; no redirect.
  - Data outs are don't-care (drive 0).
- Bubble (validIn=0, stall=0):
  - validOut=0; control outs 0.
  - Counter unchanged; bubbles are not counted.
- Flags: updated only by effective instructions with RegWrtIn=1, memToRegIn=0, PCtoRegIn=0.
  - flagN = result[DATA_W-1].
  - flagZ = (result==0).
- Branch resolution uses the flag values registered before the current edge, never the current instruction's result.
  - taken = effective & (JumpIn | (BranchZIn & flagZ) | (BranchNIn & flagN)).
- On taken:
  - redirect=1 and redirectPC=XrsIn for exactly one cycle.
  - Counter loaded with SQUASH_DEPTH.
  - The branch itself passes to EX/MEM with validOut=1 and its control bits.
- redirect = 0 on every other edge, including stalled edges.
- JumpMem is not resolved here; it is forwarded unchanged, and the target comes from memory.
- Stall:
  - Every registered output holds, except redirect, which drops to 0.
  - Counter and flags hold.
  - Stall takes priority over validIn.
- Branch arriving while counter > 0: it is squashed; no redirect; counter is not reloaded.
- Reset mid-squash: counter cleared; the first instruction after release is effective.
- Counter width: ceil(log2(SQUASH_DEPTH+1)) bits; never underflows.

Test Plan:
- ADD, Xrs=5, Xrt=7, imme=0 -> next negedge: resultOut=12, validOut=1, flagN=0, flagZ=0.
- INC, Xrs=0xFFFFFFFF, Y=1 -> resultOut=0, flagZ=1 (wrap); then NEG, Xrs=1 -> resultOut=0xFFFFFFFF, flagN=1, flagZ=0.
- SUB 3-3 (flagZ=1), then BRZ with Xrs=0x40 -> redirect=1 for one cycle with redirectPC=0x40; next 2 valid instructions give validOut=0 and RegWrtOut=0; the third passes normally. A bubble inside the window does not consume a squash slot.
- flagN=0, BRN with Xrs=0x80 -> redirect stays 0, no squash. A BRZ arriving during an active squash window -> no redirect.
- Stall held 3 cycles after ADD -> outputs and flags frozen, redirect=0. A taken J presented during stall -> no redirect until stall drops, then a single pulse.
- rst_n pulsed low asynchronously mid-squash (between edges) -> all outputs 0 immediately. After release, the first ADD gives validOut=1.
